// File: rtl/axis_iterative_divider.sv
// Radix-2 restoring divider with two independent AXI-Stream operand slaves and
// an unthrottled result master carrying {remainder, quotient} and a divide-by-zero flag.
module axis_iterative_divider #(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 aclken,
  input  logic                 s_axis_dividend_tvalid,
  output logic                 s_axis_dividend_tready,
  input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
  input  logic                 s_axis_divisor_tvalid,
  output logic                 s_axis_divisor_tready,
  input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
  output logic                 m_axis_dout_tvalid,
  output logic                 m_axis_dout_tuser,
  output logic [2*WIDTH-1:0]   m_axis_dout_tdata
);

  localparam int CW        = $clog2(WIDTH + 1);
  localparam bit IS_SIGNED = (SIGNED != 0);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             r_state, w_state_next;
  logic               r_held_a, r_held_b;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [WIDTH-1:0]   r_rem, r_quo, r_div, r_dividend;
  logic               r_qneg, r_rneg, r_dvz;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_tdata;
  logic               r_tuser;

  logic               w_rdy_a, w_rdy_b, w_hs_a, w_hs_b, w_accept, w_last;
  logic [WIDTH-1:0]   w_a_val, w_b_val, w_a_mag, w_b_mag;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH:0]     w_shift, w_trial;
  logic [WIDTH-1:0]   w_rem_next, w_quo_next;
  logic [2*WIDTH-1:0] w_result;

  assign w_rdy_a = aclken && (r_state == IDLE) && !r_held_a;
  assign w_rdy_b = aclken && (r_state == IDLE) && !r_held_b;
  assign w_hs_a  = s_axis_dividend_tvalid && w_rdy_a;
  assign w_hs_b  = s_axis_divisor_tvalid && w_rdy_b;

  // An operand handshaking in the acceptance cycle is used straight off the bus.
  assign w_a_val  = r_held_a ? r_a : s_axis_dividend_tdata;
  assign w_b_val  = r_held_b ? r_b : s_axis_divisor_tdata;
  assign w_accept = aclken && (r_state == IDLE) &&
                    (r_held_a || w_hs_a) && (r_held_b || w_hs_b);

  assign w_a_neg = IS_SIGNED && w_a_val[WIDTH-1];
  assign w_b_neg = IS_SIGNED && w_b_val[WIDTH-1];
  assign w_a_mag = w_a_neg ? -w_a_val : w_a_val;
  assign w_b_mag = w_b_neg ? -w_b_val : w_b_val;

  // Partial remainder stays below 2*|b|, so W+1 bits hold the trial difference and its sign.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_div};
  assign w_rem_next = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  assign w_result = r_dvz ? {r_dividend, {WIDTH{1'b1}}}
                          : {(r_rneg ? -w_rem_next : w_rem_next),
                             (r_qneg ? -w_quo_next : w_quo_next)};

  assign s_axis_dividend_tready = w_rdy_a;
  assign s_axis_divisor_tready  = w_rdy_b;
  assign m_axis_dout_tdata      = r_tdata;
  assign m_axis_dout_tuser      = r_tuser;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: defaults come first so no path through the case leaves a signal unassigned (no latch).
  always_comb begin
    w_state_next       = r_state;
    m_axis_dout_tvalid = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_state_next = CALC;
      CALC: if (aclken && w_last) w_state_next = DONE;
      DONE: begin
        m_axis_dout_tvalid = 1'b1;
        if (aclken) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: the datapath is reset too, because the result bus must read zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_held_a   <= 1'b0;
      r_held_b   <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_dividend <= '0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_dvz      <= 1'b0;
      r_cnt      <= '0;
      r_tdata    <= '0;
      r_tuser    <= 1'b0;
    end else if (aclken) begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_held_a   <= 1'b0;
            r_held_b   <= 1'b0;
            r_rem      <= '0;
            r_quo      <= w_a_mag;
            r_div      <= w_b_mag;
            r_dividend <= w_a_val;
            r_qneg     <= w_a_neg ^ w_b_neg;
            r_rneg     <= w_a_neg;
            r_dvz      <= (w_b_val == '0);
            r_cnt      <= '0;
          end else begin
            if (w_hs_a) begin
              r_a      <= s_axis_dividend_tdata;
              r_held_a <= 1'b1;
            end
            if (w_hs_b) begin
              r_b      <= s_axis_divisor_tdata;
              r_held_b <= 1'b1;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_tdata <= w_result;
            r_tuser <= r_dvz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_iterative_divider.sv
// Directed bench: a signed and an unsigned divider share stimulus and are checked
// against hand-computed results, latency, pulse width and handshake behaviour.
module tb_axis_iterative_divider;

  localparam int W = 32;

  typedef struct {
    int          first;
    int          count;
    int          busy;
    logic [63:0] data;
    logic        user;
    logic [63:0] last_data;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          aclken = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [W-1:0]  a_data = '0, b_data = '0;
  logic          s_rdy_a, s_rdy_b, s_tvalid, s_tuser;
  logic          u_rdy_a, u_rdy_b, u_tvalid, u_tuser;
  logic [2*W-1:0] s_tdata, u_tdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axis_iterative_divider #(.WIDTH(W), .SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .aclken(aclken),
    .s_axis_dividend_tvalid(a_valid), .s_axis_dividend_tready(s_rdy_a), .s_axis_dividend_tdata(a_data),
    .s_axis_divisor_tvalid(b_valid), .s_axis_divisor_tready(s_rdy_b), .s_axis_divisor_tdata(b_data),
    .m_axis_dout_tvalid(s_tvalid), .m_axis_dout_tuser(s_tuser), .m_axis_dout_tdata(s_tdata)
  );

  axis_iterative_divider #(.WIDTH(W), .SIGNED(0)) u_dut_u (
    .clk(clk), .reset(reset), .aclken(aclken),
    .s_axis_dividend_tvalid(a_valid), .s_axis_dividend_tready(u_rdy_a), .s_axis_dividend_tdata(a_data),
    .s_axis_divisor_tvalid(b_valid), .s_axis_divisor_tready(u_rdy_b), .s_axis_divisor_tdata(b_data),
    .m_axis_dout_tvalid(u_tvalid), .m_axis_dout_tuser(u_tuser), .m_axis_dout_tdata(u_tdata)
  );

  // Presents both operands together; returns just after the acceptance edge T.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    a_valid = 1'b1; a_data = a;
    b_valid = 1'b1; b_data = b;
    @(posedge clk);
  endtask

  // Sample k is taken in cycle T+k+1; an aclken stall may be inserted from sample stall_k.
  task automatic collect(input int stall_k, input int stall_len, input bit keep_a,
                         output obs_t os, output obs_t ou);
    os.first = -1; os.count = 0; os.busy = 0; os.data = '0; os.user = 1'b0;
    ou.first = -1; ou.count = 0; ou.busy = 0; ou.data = '0; ou.user = 1'b0;
    for (int k = 0; k < W + stall_len + 5; k++) begin
      @(negedge clk);
      if (s_tvalid) begin
        if (os.first < 0) begin os.first = k; os.data = s_tdata; os.user = s_tuser; end
        os.count++;
      end
      if ((os.first < 0 || os.first == k) && (s_rdy_a || s_rdy_b)) os.busy++;
      if (u_tvalid) begin
        if (ou.first < 0) begin ou.first = k; ou.data = u_tdata; ou.user = u_tuser; end
        ou.count++;
      end
      if ((ou.first < 0 || ou.first == k) && (u_rdy_a || u_rdy_b)) ou.busy++;
      if (k == 0) begin
        b_valid = 1'b0;
        if (!keep_a) a_valid = 1'b0;
      end
      aclken = !(k >= stall_k && k < stall_k + stall_len);
    end
    os.last_data = s_tdata;
    ou.last_data = u_tdata;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({s_tvalid, s_tuser, s_tdata} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_signed_outputs: got %h required 0", {s_tvalid, s_tuser, s_tdata});
    end
    vectors++;
    if ({u_tvalid, u_tuser, u_tdata} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_unsigned_outputs: got %h required 0", {u_tvalid, u_tuser, u_tdata});
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({s_rdy_a, s_rdy_b, u_rdy_a, u_rdy_b} !== 4'b1111) begin
      miscompares++;
      $display("FAIL reset_treadys: got %b required 1111", {s_rdy_a, s_rdy_b, u_rdy_a, u_rdy_b});
    end
  endtask

  // Checks one operation on both instances: pulse at sample exp_k, one sample wide, result held afterwards.
  task automatic test_divide(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [63:0] exp_s, input logic [63:0] exp_u,
                             input logic exp_user, input int stall_k, input int stall_len);
    obs_t os, ou;
    start_op(a, b);
    collect(stall_k, stall_len, 1'b0, os, ou);
    vectors++;
    if (os.first !== W + stall_len || ou.first !== W + stall_len) begin
      miscompares++;
      $display("FAIL %s_latency: got s=%0d u=%0d required %0d", name, os.first, ou.first, W + stall_len);
    end
    vectors++;
    if (os.count !== 1 || ou.count !== 1) begin
      miscompares++;
      $display("FAIL %s_pulse_width: got s=%0d u=%0d required 1", name, os.count, ou.count);
    end
    vectors++;
    if ({os.user, os.data} !== {exp_user, exp_s}) begin
      miscompares++;
      $display("FAIL %s_signed_result: got %h required %h", name, {os.user, os.data}, {exp_user, exp_s});
    end
    vectors++;
    if ({ou.user, ou.data} !== {exp_user, exp_u}) begin
      miscompares++;
      $display("FAIL %s_unsigned_result: got %h required %h", name, {ou.user, ou.data}, {exp_user, exp_u});
    end
    vectors++;
    if (os.last_data !== exp_s || ou.last_data !== exp_u || os.busy !== 0 || ou.busy !== 0) begin
      miscompares++;
      $display("FAIL %s_hold_and_busy: got s=%h u=%h busy=%0d/%0d required s=%h u=%h busy=0/0",
               name, os.last_data, ou.last_data, os.busy, ou.busy, exp_s, exp_u);
    end
  endtask

  task automatic test_staggered();
    obs_t os, ou;
    @(negedge clk);
    a_valid = 1'b1; a_data = 32'd100;
    vectors++;
    if (s_rdy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL stagger_ready_before: got %b required 1", s_rdy_a);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({s_rdy_a, s_rdy_b, u_rdy_a, u_rdy_b} !== 4'b0101) begin
      miscompares++;
      $display("FAIL stagger_ready_after_capture: got %b required 0101", {s_rdy_a, s_rdy_b, u_rdy_a, u_rdy_b});
    end
    a_data = 32'h999;
    @(negedge clk);
    @(negedge clk);
    b_valid = 1'b1; b_data = 32'd7;
    @(posedge clk);
    collect(-1, 0, 1'b1, os, ou);
    vectors++;
    if (os.first !== W || {os.user, os.data} !== {1'b0, 64'h00000002_0000000E}) begin
      miscompares++;
      $display("FAIL stagger_signed: got t=%0d %h required t=%0d %h", os.first, {os.user, os.data}, W, 65'h0_00000002_0000000E);
    end
    vectors++;
    if (ou.first !== W || {ou.user, ou.data} !== {1'b0, 64'h00000002_0000000E}) begin
      miscompares++;
      $display("FAIL stagger_unsigned: got t=%0d %h required t=%0d %h", ou.first, {ou.user, ou.data}, W, 65'h0_00000002_0000000E);
    end
    vectors++;
    if (os.busy !== 0 || ou.busy !== 0) begin
      miscompares++;
      $display("FAIL stagger_no_accept_busy: got %0d/%0d required 0/0", os.busy, ou.busy);
    end
    vectors++;
    if ({s_rdy_a, s_rdy_b} !== 2'b01) begin
      miscompares++;
      $display("FAIL stagger_second_dividend_held: got %b required 01", {s_rdy_a, s_rdy_b});
    end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b1; b_data = 32'd3;
    @(posedge clk);
    collect(-1, 0, 1'b0, os, ou);
    vectors++;
    if (os.first !== W || os.data !== 64'h00000000_00000333 || ou.data !== 64'h00000000_00000333) begin
      miscompares++;
      $display("FAIL stagger_second_op: got t=%0d s=%h u=%h required t=%0d %h", os.first, os.data, ou.data, W, 64'h333);
    end
  endtask

  task automatic test_reset_mid_calc();
    int highs = 0;
    start_op(32'd100, 32'd7);
    for (int k = 0; k < W + 5; k++) begin
      @(negedge clk);
      if (s_tvalid || u_tvalid) highs++;
      if (k == 0) begin a_valid = 1'b0; b_valid = 1'b0; end
      if (k == 10) reset = 1'b1;
      if (k == 12) reset = 1'b0;
    end
    vectors++;
    if (highs !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_result: got %0d tvalid samples required 0", highs);
    end
    @(negedge clk);
    a_valid = 1'b1; a_data = 32'd50;
    @(negedge clk);
    a_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({s_rdy_a, u_rdy_a} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_discards_held: got %b required 11", {s_rdy_a, u_rdy_a});
    end
    test_divide("after_reset_9_3", 32'd9, 32'd3, 64'h00000000_00000003, 64'h00000000_00000003, 1'b0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_divide("basic_100_7", 32'd100, 32'd7,
                64'h00000002_0000000E, 64'h00000002_0000000E, 1'b0, -1, 0);
    test_divide("neg7_2", 32'hFFFFFFF9, 32'd2,
                64'hFFFFFFFF_FFFFFFFD, 64'h00000001_7FFFFFFC, 1'b0, -1, 0);
    test_divide("overflow", 32'h80000000, 32'hFFFFFFFF,
                64'h00000000_80000000, 64'h80000000_00000000, 1'b0, -1, 0);
    test_divide("div0_pos", 32'd5, 32'd0,
                64'h00000005_FFFFFFFF, 64'h00000005_FFFFFFFF, 1'b1, -1, 0);
    test_divide("div0_neg", 32'hFFFFFFF8, 32'd0,
                64'hFFFFFFF8_FFFFFFFF, 64'hFFFFFFF8_FFFFFFFF, 1'b1, -1, 0);
    test_divide("aclken_stall", 32'd100, 32'd7,
                64'h00000002_0000000E, 64'h00000002_0000000E, 1'b0, 10, 5);
    test_staggered();
    test_reset_mid_calc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
